// File: rtl/paddle_input_mapper.sv
// paddle_input_mapper: maps analog/digital stick input to paddle positions and PS/2 keys to start/coin levels
module paddle_input_mapper #(
  parameter int NUM_PLAYERS = 2,
  parameter int POS_W       = 8,
  parameter int RAMP_STEP   = 2,
  parameter int TICK_DIV    = 7159
) (
  input  logic                           i_clk_sys,
  input  logic                           i_reset_n,
  input  logic [16*NUM_PLAYERS-1:0]      i_joy_analog,
  input  logic [16*NUM_PLAYERS-1:0]      i_joy_digital,
  input  logic [3*NUM_PLAYERS-1:0]       i_mode,
  input  logic [10:0]                    i_ps2_key,
  output logic [POS_W*NUM_PLAYERS-1:0]   o_paddle_vpos,
  output logic [NUM_PLAYERS-1:0]         o_start_btn,
  output logic [NUM_PLAYERS-1:0]         o_coin_btn
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] STEP = POS_W'(RAMP_STEP);
  localparam logic [POS_W-1:0] MAXV = {POS_W{1'b1}};
  localparam logic [POS_W-1:0] MID = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic [31:0] START_CODES = {8'h25, 8'h26, 8'h1E, 8'h16};
  localparam logic [31:0] COIN_CODES  = {8'h3E, 8'h3D, 8'h36, 8'h2E};
  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_tick;
  logic             r_primed;
  logic             r_old_toggle;
  logic             w_event;
  assign w_tick  = (r_tick_cnt == TICK_LAST);
  assign w_event = r_primed & (i_ps2_key[10] ^ r_old_toggle);
  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tick_cnt   <= '0;
      r_primed     <= 1'b0;
      r_old_toggle <= 1'b0;
    end else begin
      r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
      r_primed     <= 1'b1;
      r_old_toggle <= i_ps2_key[10];
    end
  end
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    logic [7:0]       w_x;
    logic [7:0]       w_y;
    logic [7:0]       w_a8;
    logic [15:0]      w_rep;
    logic [2:0]       w_mode;
    logic             w_up;
    logic             w_dn;
    logic             w_dig;
    logic             w_enter;
    logic             w_hit_start;
    logic             w_hit_coin;
    logic             w_key_start_nxt;
    logic             w_key_coin_nxt;
    logic [POS_W-1:0] w_ramp_nxt;
    logic [POS_W-1:0] w_vpos_nxt;
    logic [POS_W-1:0] r_ramp;
    logic [POS_W-1:0] r_vpos;
    logic [2:0]       r_mode_prev;
    logic             r_key_start;
    logic             r_key_coin;
    logic             r_start;
    logic             r_coin;
    assign w_x   = i_joy_analog[16*g +: 8];
    assign w_y   = i_joy_analog[16*g+8 +: 8];
    assign w_mode = i_mode[3*g +: 3];
    assign w_up  = i_joy_digital[16*g+3];
    assign w_dn  = i_joy_digital[16*g+2];
    assign w_dig = (w_mode == 3'd4);
    assign w_enter = w_dig && (r_mode_prev != 3'd4);
    assign w_hit_start = w_event && !i_ps2_key[8] && (i_ps2_key[7:0] == START_CODES[8*g +: 8]);
    assign w_hit_coin  = w_event && !i_ps2_key[8] && (i_ps2_key[7:0] == COIN_CODES[8*g +: 8]);
    always_comb begin
      w_a8 = (w_mode == 3'd1) ? w_x + 8'h80 :
             (w_mode == 3'd2) ? w_x ^ 8'h7F :
             (w_mode == 3'd3) ? w_y ^ 8'h7F : w_y + 8'h80;
      w_rep = {w_a8, w_a8};
      // Entry into digital mode seeds the ramp from the current position so the paddle does not jump
      w_ramp_nxt = w_enter ? r_vpos :
                   (w_dig && w_tick && w_up && !w_dn) ? ((r_ramp < STEP) ? '0 : r_ramp - STEP) :
                   (w_dig && w_tick && w_dn && !w_up) ? ((r_ramp > MAXV - STEP) ? MAXV : r_ramp + STEP) :
                   r_ramp;
      w_vpos_nxt = w_enter ? r_vpos : w_dig ? r_ramp : w_rep[15 -: POS_W];
      w_key_start_nxt = w_hit_start ? i_ps2_key[9] : r_key_start;
      w_key_coin_nxt  = w_hit_coin  ? i_ps2_key[9] : r_key_coin;
    end
    always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_ramp      <= MID;
        r_vpos      <= MID;
        r_mode_prev <= 3'd0;
        r_key_start <= 1'b0;
        r_key_coin  <= 1'b0;
        r_start     <= 1'b0;
        r_coin      <= 1'b0;
      end else begin
        r_ramp      <= w_ramp_nxt;
        r_vpos      <= w_vpos_nxt;
        r_mode_prev <= w_mode;
        r_key_start <= w_key_start_nxt;
        r_key_coin  <= w_key_coin_nxt;
        r_start     <= w_key_start_nxt | i_joy_digital[16*g+4];
        r_coin      <= w_key_coin_nxt | i_joy_digital[16*g+5];
      end
    end
    assign o_paddle_vpos[POS_W*g +: POS_W] = r_vpos;
    assign o_start_btn[g] = r_start;
    assign o_coin_btn[g]  = r_coin;
  end
endmodule
